sdram_arbiter: RTL and testbench

Slot scheduler that shares the single-port SDRAM controller between three requesters: video fetch, CPU and DMA (ROM/disk loader). It owns the 8-cycle memory slot timing and generates the controller's `sync` strobe. Each slot it latches one request onto the controller's command inputs and returns read data with a one-cycle acknowledge. It also guarantees idle slots for auto-refresh and bounds DMA starvation.

---
 rtl/sdram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Slot scheduler sharing one SDRAM controller between video, CPU and DMA.
// Eight-cycle slots; owner chosen and command registered at the end of phase 7.
module sdram_arbiter #(
  parameter int REFRESH_SLOTS = 64,
  parameter int STARVE_SLOTS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic [23:0] vid_addr,
  input  logic [23:0] cpu_addr,
  input  logic [23:0] dma_addr,
  input  logic [15:0] cpu_din,
  input  logic [15:0] dma_din,
  input  logic [1:0]  cpu_ds,
  input  logic [1:0]  dma_ds,
  input  logic        cpu_we,
  input  logic        dma_we,
  output logic        vid_ack,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [15:0] vid_rdata,
  output logic [15:0] cpu_rdata,
  output logic [15:0] dma_rdata,
  output logic        mem_sync,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_VID  = 2'd1,
    O_CPU  = 2'd2,
    O_DMA  = 2'd3
  } owner_t;

  owner_t      owner;
  owner_t      nxt;
  logic [2:0]  phase;
  logic [6:0]  since_idle;
  logic [2:0]  dma_wait;
  logic        vid_ok;
  logic        cpu_ok;
  logic        dma_ok;

  assign grant = owner;

  // The owner of the ending slot may not win the next one.
  always_comb begin
    vid_ok = vid_req && (owner != O_VID);
    cpu_ok = cpu_req && (owner != O_CPU);
    dma_ok = dma_req && (owner != O_DMA);
    nxt    = O_IDLE;
    if (int'(since_idle) == REFRESH_SLOTS)
      nxt = O_IDLE;
    else if (dma_ok && int'(dma_wait) >= STARVE_SLOTS)
      nxt = O_DMA;
    else if (vid_ok)
      nxt = O_VID;
    else if (cpu_ok)
      nxt = O_CPU;
    else if (dma_ok)
      nxt = O_DMA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 3'd0;
      mem_sync   <= 1'b1;
      owner      <= O_IDLE;
      mem_addr   <= 24'd0;
      mem_din    <= 16'd0;
      mem_ds     <= 2'd0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      vid_rdata  <= 16'd0;
      cpu_rdata  <= 16'd0;
      dma_rdata  <= 16'd0;
      since_idle <= 7'd0;
      dma_wait   <= 3'd0;
    end else begin
      phase    <= phase + 3'd1;
      mem_sync <= (phase == 3'd7) || (phase < 3'd3);
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      if (phase == 3'd7) begin
        // Complete the ending slot.
        unique case (owner)
          O_VID: begin
            vid_ack <= 1'b1;
            if (mem_oe) vid_rdata <= mem_dout;
          end
          O_CPU: begin
            cpu_ack <= 1'b1;
            if (mem_oe) cpu_rdata <= mem_dout;
          end
          O_DMA: begin
            dma_ack <= 1'b1;
            if (mem_oe) dma_rdata <= mem_dout;
          end
          default: ;
        endcase
        owner <= nxt;
        unique case (nxt)
          O_VID: begin
            mem_addr <= vid_addr;
            mem_din  <= 16'd0;
            mem_ds   <= 2'b11;
            mem_oe   <= 1'b1;
            mem_we   <= 1'b0;
          end
          O_CPU: begin
            mem_addr <= cpu_addr;
            mem_din  <= cpu_din;
            mem_ds   <= cpu_ds;
            mem_oe   <= ~cpu_we;
            mem_we   <= cpu_we;
          end
          O_DMA: begin
            mem_addr <= dma_addr;
            mem_din  <= dma_din;
            mem_ds   <= dma_ds;
            mem_oe   <= ~dma_we;
            mem_we   <= dma_we;
          end
          default: begin
            mem_addr <= 24'd0;
            mem_din  <= 16'd0;
            mem_ds   <= 2'd0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
          end
        endcase
        if (nxt == O_IDLE)
          since_idle <= 7'd0;
        else if (since_idle != 7'h7f)
          since_idle <= since_idle + 7'd1;
        if (nxt == O_DMA || !dma_req)
          dma_wait <= 3'd0;
        else if (dma_wait != 3'd7)
          dma_wait <= dma_wait + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot timing, priority, refresh, writes
// and mid-slot reset, with expected grants/rdata held in scoreboard queues.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req, cpu_req, dma_req;
  logic [23:0] vid_addr, cpu_addr, dma_addr;
  logic [15:0] cpu_din, dma_din;
  logic [1:0]  cpu_ds, dma_ds;
  logic        cpu_we, dma_we;
  logic        vid_ack, cpu_ack, dma_ack;
  logic [15:0] vid_rdata, cpu_rdata, dma_rdata;
  logic        mem_sync;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_oe, mem_we;
  logic [15:0] mem_dout;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;
  logic [2:0] tb_ph;
  int exp_grant[$];
  logic [15:0] exp_cpu_rd[$];

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .cpu_req(cpu_req), .dma_req(dma_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
    .cpu_din(cpu_din), .dma_din(dma_din),
    .cpu_ds(cpu_ds), .dma_ds(dma_ds),
    .cpu_we(cpu_we), .dma_we(dma_we),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .vid_rdata(vid_rdata), .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
    .mem_sync(mem_sync), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ds(mem_ds), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_dout(mem_dout), .grant(grant)
  );

  always #5 clk = ~clk;

  // Independent phase model of the slot timing.
  always @(posedge clk or posedge reset)
    if (reset) tb_ph <= 3'd0;
    else tb_ph <= tb_ph + 3'd1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_slot();
    int n = 0;
    @(negedge clk);
    while (tb_ph != 3'd0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) chk("slot_timeout", 32'd1, 32'd0);
  endtask

  // Starting at phase 0, check the held command across all 8 phases.
  task automatic chk_slot(input logic [1:0] g, input logic oe,
                          input logic we, input logic [23:0] a,
                          input logic [15:0] d, input logic [1:0] ds);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("slot_grant", grant, g);
      chk("slot_oe", mem_oe, oe);
      chk("slot_we", mem_we, we);
      chk("slot_addr", mem_addr, a);
      chk("slot_din", mem_din, d);
      chk("slot_ds", mem_ds, ds);
      chk("slot_sync", mem_sync, tb_ph < 3'd4);
    end
  endtask

  initial begin
    int prev, run, idles, e;
    reset = 1'b1;
    {vid_req, cpu_req, dma_req} = 3'b000;
    vid_addr = 24'd0; cpu_addr = 24'd0; dma_addr = 24'd0;
    cpu_din = 16'd0; dma_din = 16'd0;
    cpu_ds = 2'b11; dma_ds = 2'b11;
    cpu_we = 1'b0; dma_we = 1'b0;
    mem_dout = 16'd0;

    // Reset state
    @(negedge clk);
    chk("rst_grant", grant, 2'd0);
    chk("rst_sync", mem_sync, 1'b1);
    chk("rst_oe_we", {mem_oe, mem_we}, 2'b00);
    chk("rst_addr", mem_addr, 24'd0);
    chk("rst_din_ds", {mem_din, mem_ds}, 18'd0);
    chk("rst_acks", {vid_ack, cpu_ack, dma_ack}, 3'b000);
    chk("rst_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 48'd0);
    reset = 1'b0;

    // CPU read in the idle first slot
    cpu_req = 1'b1; cpu_addr = 24'h000123;
    exp_cpu_rd.push_back(16'hBEEF);
    next_slot();
    mem_dout = 16'hBEEF;
    chk_slot(2'd2, 1'b1, 1'b0, 24'h000123, 16'd0, 2'b11);
    next_slot();
    chk("rd_ack", cpu_ack, 1'b1);
    chk("rd_rdata", cpu_rdata, exp_cpu_rd.pop_front());
    chk("rd_after_grant", grant, 2'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_one_cycle", cpu_ack, 1'b0);
    chk("rd_rdata_held", cpu_rdata, 16'hBEEF);

    // Video and CPU alternate
    next_slot();
    vid_req = 1'b1; cpu_req = 1'b1;
    vid_addr = 24'h000222; cpu_addr = 24'h000111;
    mem_dout = 16'h5A5A;
    exp_grant = '{1, 2, 1, 2};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      next_slot();
      e = exp_grant.pop_front();
      chk("alt_grant", grant, e[1:0]);
      chk("alt_vid_ack", vid_ack, prev == 1);
      if (e == 1) begin
        chk("vid_ds", mem_ds, 2'b11);
        chk("vid_din", mem_din, 16'd0);
        chk("vid_addr", mem_addr, 24'h000222);
      end
      prev = e;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    exp_cpu_rd.push_back(16'h5A5A);
    next_slot();
    chk("alt_end_idle", grant, 2'd0);
    chk("alt_cpu_ack", cpu_ack, 1'b1);
    chk("alt_cpu_rdata", cpu_rdata, exp_cpu_rd.pop_front());
    chk("alt_vid_rdata", vid_rdata, 16'h5A5A);

    // All three held: starvation promotion, then refresh forcing
    vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    dma_addr = 24'h000333;
    exp_grant = '{1, 2, 1, 2, 3, 1, 2, 1, 2, 3};
    for (int i = 0; i < 10; i++) begin
      next_slot();
      e = exp_grant.pop_front();
      chk("starve_grant", grant, e[1:0]);
      if (e == 3) chk("dma_addr", mem_addr, 24'h000333);
    end
    run = 10; idles = 0; prev = grant;
    for (int i = 0; i < 190; i++) begin
      next_slot();
      if (grant == 2'd0) begin
        chk("refresh_run", run, 64);
        idles++;
        run = 0;
      end else begin
        run++;
        chk("run_bound", run <= 64, 1'b1);
        chk("no_back_to_back", grant != prev[1:0], 1'b1);
      end
      prev = grant;
    end
    chk("refresh_count", idles, 3);
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    next_slot();
    chk("drop_idle", grant, 2'd0);

    // CPU write: rdata must not change
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_din = 16'h1234;
    cpu_ds = 2'b01; cpu_addr = 24'h00ABCD;
    exp_cpu_rd.push_back(cpu_rdata === 16'h5A5A ? 16'h5A5A : 16'h5A5A);
    next_slot();
    mem_dout = 16'hDEAD;
    chk_slot(2'd2, 1'b0, 1'b1, 24'h00ABCD, 16'h1234, 2'b01);
    next_slot();
    chk("wr_ack", cpu_ack, 1'b1);
    chk("wr_rdata_kept", cpu_rdata, exp_cpu_rd.pop_front());
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_din = 16'd0;

    // Reset in phase 4 of a CPU slot
    next_slot();
    chk("pre_rst_idle", grant, 2'd0);
    cpu_req = 1'b1; cpu_addr = 24'h000456;
    next_slot();
    chk("mid_grant", grant, 2'd2);
    repeat (4) @(negedge clk);
    chk("mid_phase", tb_ph, 3'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 2'd0);
    chk("mid_rst_cmd", {mem_oe, mem_we, mem_ds}, 4'd0);
    chk("mid_rst_addr", mem_addr, 24'd0);
    chk("mid_rst_sync", mem_sync, 1'b1);
    chk("mid_rst_rdata", cpu_rdata, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("post_rst_idle", grant, 2'd0);
      chk("post_rst_no_ack", cpu_ack, 1'b0);
    end
    next_slot();
    chk("post_rst_grant", grant, 2'd2);
    chk("post_rst_addr", mem_addr, 24'h000456);
    next_slot();
    chk("post_rst_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
